// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared variant codes, FSM states and size/extension helpers
package dmem_pkg;

   localparam logic [2:0] VAR_B  = 3'b000;
   localparam logic [2:0] VAR_H  = 3'b001;
   localparam logic [2:0] VAR_W  = 3'b010;
   localparam logic [2:0] VAR_HU = 3'b100;
   localparam logic [2:0] VAR_BU = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_XFER = 2'd1,
      S_LAST = 2'd2,
      S_DONE = 2'd3
   } state_t;

   function automatic logic [2:0] nbytes(input logic [2:0] v);
      case (v)
         VAR_B, VAR_BU: return 3'd1;
         VAR_H, VAR_HU: return 3'd2;
         default:       return 3'd4;
      endcase
   endfunction

   // Unknown variant codes fall through to a plain word.
   function automatic logic [31:0] extend(input logic [2:0] v, input logic [31:0] a);
      case (v)
         VAR_B:   return {{24{a[7]}}, a[7:0]};
         VAR_BU:  return {24'b0, a[7:0]};
         VAR_H:   return {{16{a[15]}}, a[15:0]};
         VAR_HU:  return {16'b0, a[15:0]};
         default: return a;
      endcase
   endfunction

endpackage

// File: rtl/dmem_arb_seq_if.sv
// rtl/dmem_arb_seq_if.sv - requester ports and byte-RAM bus of the data memory arbiter
interface dmem_arb_seq_if #(
   parameter int ADDR_W = 7
);
   logic              req0, req1;
   logic              we0, we1;
   logic [2:0]        var0, var1;
   logic [31:0]       addr0, addr1;
   logic [31:0]       wdata0, wdata1;
   logic              gnt0, gnt1;
   logic              done0, done1;
   logic [31:0]       rdata;
   logic              busy;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [7:0]        mem_wdata;
   logic [7:0]        mem_rdata;

   modport slave (
      input  req0, req1, we0, we1, var0, var1, addr0, addr1, wdata0, wdata1, mem_rdata,
      output gnt0, gnt1, done0, done1, rdata, busy, mem_addr, mem_we, mem_wdata
   );

   modport master (
      output req0, req1, we0, we1, var0, var1, addr0, addr1, wdata0, wdata1, mem_rdata,
      input  gnt0, gnt1, done0, done1, rdata, busy, mem_addr, mem_we, mem_wdata
   );
endinterface

// File: rtl/dmem_rr_arb.sv
// rtl/dmem_rr_arb.sv - two-port round-robin arbiter with one-hot grant
module dmem_rr_arb (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant
);
   logic prio1;

   // prio1 set means port 1 wins a tie; it flips to the loser on every grant.
   always_comb begin
      grant = 2'b00;
      if (req == 2'b11) grant = prio1 ? 2'b10 : 2'b01;
      else              grant = req;
   end

   always_ff @(posedge clk) begin
      if (!reset_n)     prio1 <= 1'b0;
      else if (advance) prio1 <= grant[0];
   end
endmodule

// File: rtl/dmem_arb_seq.sv
// rtl/dmem_arb_seq.sv - shares a byte RAM between two ports, sequencing big-endian multi-byte accesses
module dmem_arb_seq
   import dmem_pkg::*;
#(
   parameter int ADDR_W = 7
) (
   input  logic          clk,
   input  logic          reset_n,
   dmem_arb_seq_if.slave bus
);
   state_t            state, state_nx;
   logic [1:0]        arb_req, grant;
   logic              take;
   logic              owner, we_l;
   logic [2:0]        var_l;
   logic [31:0]       wdata_l, asm_q, rdata_q;
   logic [1:0]        k;
   logic [2:0]        n_l;
   logic              last_k;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [7:0]        mem_wdata_q;
   logic              we_s;
   logic [2:0]        var_s;
   logic [31:0]       addr_s, wdata_s;
   logic              unused_addr_hi;

   function automatic logic [7:0] pick(input logic [31:0] d, input logic [2:0] n, input logic [1:0] idx);
      logic [1:0]  sel;
      logic [31:0] s;
      sel = 2'(n - 3'd1 - {1'b0, idx});
      s   = d >> {sel, 3'b000};
      return s[7:0];
   endfunction

   assign arb_req = (state == S_IDLE && reset_n) ? {bus.req1, bus.req0} : 2'b00;
   assign take    = |grant;

   dmem_rr_arb u_arb (
      .clk     (clk),
      .reset_n (reset_n),
      .req     (arb_req),
      .advance (take),
      .grant   (grant)
   );

   assign we_s    = grant[1] ? bus.we1    : bus.we0;
   assign var_s   = grant[1] ? bus.var1   : bus.var0;
   assign addr_s  = grant[1] ? bus.addr1  : bus.addr0;
   assign wdata_s = grant[1] ? bus.wdata1 : bus.wdata0;
   assign unused_addr_hi = ^{bus.addr0[31:ADDR_W], bus.addr1[31:ADDR_W]};

   assign n_l    = nbytes(var_l);
   assign last_k = (k == 2'(n_l - 3'd1));

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (take) state_nx = S_XFER;
         S_XFER:  if (last_k) state_nx = we_l ? S_DONE : S_LAST;
         S_LAST:  state_nx = S_DONE;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // mem_* are registered one cycle ahead: set up in the grant cycle, advanced during XFER.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         owner       <= 1'b0;
         we_l        <= 1'b0;
         var_l       <= VAR_W;
         wdata_l     <= '0;
         k           <= '0;
         asm_q       <= '0;
         rdata_q     <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state <= state_nx;
         case (state)
            S_IDLE: if (take) begin
               owner       <= grant[1];
               we_l        <= we_s;
               var_l       <= var_s;
               wdata_l     <= wdata_s;
               k           <= '0;
               asm_q       <= '0;
               mem_addr_q  <= addr_s[ADDR_W-1:0];
               mem_we_q    <= we_s;
               mem_wdata_q <= pick(wdata_s, nbytes(var_s), 2'd0);
            end
            S_XFER: begin
               // The byte read for k-1 arrives while k is presented.
               if (k != 2'd0) asm_q <= {asm_q[23:0], bus.mem_rdata};
               if (last_k) begin
                  mem_we_q <= 1'b0;
               end else begin
                  k           <= k + 2'd1;
                  mem_addr_q  <= mem_addr_q + ADDR_W'(1);
                  mem_wdata_q <= pick(wdata_l, n_l, k + 2'd1);
               end
            end
            S_LAST: rdata_q <= extend(var_l, {asm_q[23:0], bus.mem_rdata});
            default: ;
         endcase
      end
   end

   // Gating with reset_n makes a mid-access reset stop writes in the very cycle it is asserted.
   assign bus.gnt0      = grant[0];
   assign bus.gnt1      = grant[1];
   assign bus.done0     = reset_n && state == S_DONE && !owner;
   assign bus.done1     = reset_n && state == S_DONE && owner;
   assign bus.busy      = reset_n && (state != S_IDLE || take);
   assign bus.rdata     = reset_n ? rdata_q : '0;
   assign bus.mem_we    = mem_we_q && reset_n;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_dmem_arb_seq.sv
// tb/tb_dmem_arb_seq.sv - transaction-level model check of dmem_arb_seq with directed accesses
module tb_dmem_arb_seq;
   logic clk = 1'b0;
   logic reset_n;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   bit [7:0] ram     [128];
   bit [7:0] ref_mem [128];

   dmem_arb_seq_if #(.ADDR_W(7)) bus ();

   dmem_arb_seq #(.ADDR_W(7)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= ram[bus.mem_addr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int nb(input logic [2:0] v);
      case (v)
         3'b000, 3'b101: return 1;
         3'b001, 3'b100: return 2;
         default:        return 4;
      endcase
   endfunction

   function automatic logic [31:0] exp_load(input logic [2:0] v, input int a);
      int     n;
      longint val;
      n   = nb(v);
      val = 0;
      for (int i = 0; i < n; i++) val = val * 256 + longint'(ref_mem[(a + i) % 128]);
      if ((v == 3'b000 || v == 3'b001) && val >= (longint'(1) << (8 * n - 1)))
         val -= (longint'(1) << (8 * n));
      return val[31:0];
   endfunction

   bit          m_active = 0;
   bit          m_ptr = 0;
   bit          m_own, m_we;
   int          m_t, m_n, m_addr, m_done_rel;
   logic [2:0]  m_var;
   logic [31:0] m_wd, m_load, m_rdata = '0;

   always @(negedge clk) begin : model_check
      int          rel, w;
      logic [31:0] sh;
      if (reset_n !== 1'b1) begin
         chk("rst_gnt",   {bus.gnt1, bus.gnt0}, 0);
         chk("rst_done",  {bus.done1, bus.done0}, 0);
         chk("rst_busy",  bus.busy, 0);
         chk("rst_we",    bus.mem_we, 0);
         chk("rst_rdata", bus.rdata, 0);
         m_active = 0;
         m_ptr    = 0;
         m_rdata  = '0;
      end else if (!m_active) begin
         chk("idle_done", {bus.done1, bus.done0}, 0);
         chk("idle_we",   bus.mem_we, 0);
         chk("idle_busy", bus.busy, bus.req0 | bus.req1);
         chk("rdata",     bus.rdata, m_rdata);
         w = (bus.req0 && bus.req1) ? (m_ptr ? 1 : 0) : (bus.req1 ? 1 : 0);
         if (bus.req0 || bus.req1) begin
            chk("gnt0", bus.gnt0, w == 0);
            chk("gnt1", bus.gnt1, w == 1);
            m_active   = 1;
            m_own      = w[0];
            m_t        = cyc;
            m_we       = w ? bus.we1 : bus.we0;
            m_var      = w ? bus.var1 : bus.var0;
            m_addr     = int'(w ? bus.addr1[6:0] : bus.addr0[6:0]);
            m_wd       = w ? bus.wdata1 : bus.wdata0;
            m_n        = nb(m_var);
            m_done_rel = m_we ? m_n + 1 : m_n + 2;
            m_load     = m_we ? 32'h0 : exp_load(m_var, m_addr);
            m_ptr      = (w == 0);
         end else begin
            chk("idle_gnt", {bus.gnt1, bus.gnt0}, 0);
         end
      end else begin
         rel = cyc - m_t;
         chk("busy_gnt", {bus.gnt1, bus.gnt0}, 0);
         chk("busy",     bus.busy, 1);
         if (rel >= 1 && rel <= m_n) begin
            chk("mem_we",   bus.mem_we, m_we);
            chk("mem_addr", 32'(bus.mem_addr), 32'((m_addr + rel - 1) % 128));
            if (m_we) begin
               sh = m_wd >> (8 * (m_n - rel));
               chk("mem_wdata", bus.mem_wdata, sh[7:0]);
               ref_mem[(m_addr + rel - 1) % 128] = sh[7:0];
            end
         end else begin
            chk("xfer_we_off", bus.mem_we, 0);
         end
         if (rel == m_done_rel) begin
            chk("done_own",   m_own ? bus.done1 : bus.done0, 1);
            chk("done_other", m_own ? bus.done0 : bus.done1, 0);
            if (!m_we) m_rdata = m_load;
            m_active = 0;
         end else begin
            chk("no_done", {bus.done1, bus.done0}, 0);
         end
         chk("rdata", bus.rdata, m_rdata);
      end
   end

   int          last_lat;
   logic [31:0] last_rdata;

   task automatic do_access(input bit p, input bit we, input logic [2:0] v,
                            input logic [31:0] a, input logic [31:0] wd);
      int g;
      bit ok;
      @(posedge clk); #1;
      if (p) begin
         bus.req1 = 1; bus.we1 = we; bus.var1 = v; bus.addr1 = a; bus.wdata1 = wd;
      end else begin
         bus.req0 = 1; bus.we0 = we; bus.var0 = v; bus.addr0 = a; bus.wdata0 = wd;
      end
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (p ? bus.gnt1 : bus.gnt0) ok = 1;
      end
      if (!ok) chk("gnt_timeout", 0, 1);
      g = cyc;
      @(posedge clk); #1;
      if (p) bus.req1 = 0; else bus.req0 = 0;
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (p ? bus.done1 : bus.done0) ok = 1;
      end
      if (!ok) chk("done_timeout", 0, 1);
      last_lat   = cyc - g;
      last_rdata = bus.rdata;
   endtask

   task automatic do_reset();
      @(posedge clk); #1 reset_n = 0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int      order[$];
      bit      ok;
      bit [7:0] snap21;
      reset_n = 0;
      bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
      bus.var0 = 0; bus.var1 = 0; bus.addr0 = 0; bus.addr1 = 0;
      bus.wdata0 = 0; bus.wdata1 = 0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1;

      do_access(0, 1, 3'b010, 32'd8, 32'hA1B2C3D4);
      chk("t1_lat", last_lat, 5);
      chk("t1_ram8", ram[8], 8'hA1);
      chk("t1_ram11", ram[11], 8'hD4);

      do_access(1, 1, 3'b010, 32'd8, 32'h80010203);
      do_access(0, 0, 3'b000, 32'd8, 0);  chk("t2_b",  last_rdata, 32'hFFFFFF80);
      do_access(1, 0, 3'b101, 32'd8, 0);  chk("t2_bu", last_rdata, 32'h00000080);
      do_access(0, 0, 3'b001, 32'd8, 0);  chk("t2_h",  last_rdata, 32'hFFFF8001);
      do_access(0, 0, 3'b100, 32'd8, 0);  chk("t2_hu", last_rdata, 32'h00008001);
      do_access(1, 0, 3'b010, 32'd8, 0);  chk("t2_w",  last_rdata, 32'h80010203);
      chk("t2_lat", last_lat, 6);

      do_access(0, 1, 3'b010, 32'h0000_017E, 32'h11223344);
      chk("t4_ram127", ram[127], 8'h22);
      chk("t4_ram0", ram[0], 8'h33);
      do_access(1, 0, 3'b010, 32'd126, 0); chk("t4_load", last_rdata, 32'h11223344);
      do_access(0, 1, 3'b011, 32'd9, 32'hDEAD0001);  chk("t_rd_kept", last_rdata, 32'h11223344);

      do_access(0, 1, 3'b111, 32'd40, 32'hCAFEBABE);
      chk("t6_lat", last_lat, 5);
      do_access(1, 0, 3'b111, 32'd40, 0); chk("t6_111", last_rdata, 32'hCAFEBABE);
      do_access(0, 0, 3'b011, 32'd40, 0); chk("t6_011", last_rdata, 32'hCAFEBABE);
      chk("t6_lat_ld", last_lat, 6);

      snap21 = ram[21];
      @(posedge clk); #1;
      bus.req0 = 1; bus.we0 = 1; bus.var0 = 3'b010; bus.addr0 = 32'd20; bus.wdata0 = 32'h99887766;
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (bus.gnt0) ok = 1;
      end
      if (!ok) chk("t5_gnt_timeout", 0, 1);
      @(posedge clk); #1 bus.req0 = 0;
      @(posedge clk); #1 reset_n = 0;
      @(negedge clk);
      chk("t5_we", bus.mem_we, 0);
      chk("t5_busy", bus.busy, 0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1;
      repeat (8) @(negedge clk) chk("t5_no_done", bus.done0, 0);
      chk("t5_ram20", ram[20], 8'h99);
      chk("t5_ram21", ram[21], snap21);
      chk("t5_rdata", bus.rdata, 0);

      do_reset();
      @(posedge clk); #1;
      bus.req0 = 1; bus.req1 = 1; bus.we0 = 0; bus.we1 = 0;
      bus.var0 = 3'b000; bus.var1 = 3'b000; bus.addr0 = 32'd8; bus.addr1 = 32'd9;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.gnt0) order.push_back(0);
         if (bus.gnt1) order.push_back(1);
      end
      @(posedge clk); #1 bus.req0 = 0; bus.req1 = 0;
      repeat (8) @(posedge clk);
      chk("t3_count", order.size() >= 4, 1);
      for (int i = 0; i < 4; i++)
         if (order.size() > i) chk("t3_order", order[i], i % 2);

      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/dmem_arb_seq.md
Name: dmem_arb_seq

Overview:
Shares the byte-wide data RAM between two requesters: port 0 is the core load/store unit and port 1 is the debug/DMA loader. Each granted access is sequenced into 1, 2 or 4 single-byte RAM cycles, using big-endian byte order (the byte at the lowest address is the MSB). For loads, the block assembles the bytes and applies sign or zero extension according to the codebase's funct3 load/store variant encoding. It sits between the LSU/debug ports and the synchronous byte RAM.

Parameters:
ADDR_W, 7, byte-address width of the RAM (DEPTH = 2**ADDR_W = 128 bytes); all addresses are taken modulo DEPTH.

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  synchronous active-low reset
req0 / req1  in  1  access request, port 0 / port 1; must be held until gnt of that port
we0 / we1  in  1  1 = store, 0 = load
var0 / var1  in  3  variant: 000 byte, 001 half, 010 word, 100 half unsigned, 101 byte unsigned; any other code = word
addr0 / addr1  in  32  byte address; bits [ADDR_W-1:0] are used
wdata0 / wdata1  in  32  store data; the low 8/16/32 bits are stored
gnt0 / gnt1  out  1  one-cycle pulse; the request fields are captured in this cycle
done0 / done1  out  1  one-cycle completion pulse
rdata  out  32  load result; valid with done, held until the next load completes
busy  out  1  high from the gnt cycle through the done cycle
mem_addr  out  ADDR_W  RAM byte address
mem_we  out  1  RAM byte write enable
mem_wdata  out  8  RAM write byte
mem_rdata  in  8  RAM read byte, valid the cycle after mem_addr is presented with mem_we=0

Behaviour:
- Reset (reset_n=0 at a clk edge) forces all outputs to 0 and the FSM to IDLE, and sets the round-robin pointer to favour port 0.
- Reset during an access aborts it: no further mem_we, no done pulse, partially written bytes stay in RAM.
- FSM states:
  - IDLE -> XFER when any req is high and busy=0. The winner's gnt pulses in that cycle (cycle T), and its we/var/addr/wdata are latched.
  - XFER: byte counter k runs 0..n-1, with mem_addr = (addr+k) mod DEPTH.
  - LAST (loads only): captures the final byte.
  - DONE: one cycle, done of the owner is pulsed, then the FSM returns to IDLE. A request pending in DONE is arbitrated in the following IDLE cycle.
- Byte count n: byte variants (000, 101) = 1; half variants (001, 100) = 2; everything else = 4.
- Store: cycles T+1..T+n drive mem_we=1, writing bytes MSB-first.
  - Example for a word: k=0 writes wdata[31:24], k=3 writes wdata[7:0].
  - Half: wdata[15:8] then wdata[7:0].
  - Byte: wdata[7:0].
  - done pulses at T+n+1.
- Load: reads are issued T+1..T+n with mem_we=0, and byte k is captured at T+k+2. done pulses and rdata updates at T+n+2.
  - 000: sign-extend the byte from bit 7.
  - 001: sign-extend the half from bit 15.
  - 100 / 101: zero-extend.
  - Word: the 4 bytes concatenated in order.
- Address wrap: addr+k wraps modulo DEPTH; for example, a word at address 126 touches 126, 127, 0, 1. Misaligned accesses are legal.
- Arbitration is round-robin over 2 ports.
  - If both ports request in IDLE, the port not granted most recently wins.
  - With a single requester, that requester wins regardless of the pointer.
  - The pointer updates on each gnt.
- A req deasserted before its gnt is simply dropped. A req held high after done is treated as a new access.
- Outside XFER, mem_we=0 and mem_addr/mem_wdata hold their last value. rdata is unchanged by stores.

Decomposition:
- Shared package dmem_pkg contains:
  - variant localparams: VAR_B=000, VAR_H=001, VAR_W=010, VAR_HU=100, VAR_BU=101;
  - the FSM state encoding (IDLE, XFER, LAST, DONE);
  - function nbytes(var) returning 1, 2 or 4;
  - function extend(var, assembled) for sign/zero extension.
- One sub-module, dmem_rr_arb: a 2-port round-robin arbiter with inputs req[1:0] and advance, and output a one-hot grant.

Test Plan:
1. Port 0 store word 0xA1B2C3D4 at addr 8 -> gnt0 at T; mem_we at T+1..T+4 writing A1,B2,C3,D4 to addrs 8..11; done0 at T+5.
2. RAM bytes 8..11 = 0x80,0x01,0x02,0x03:
   - var 000 at addr 8 -> rdata 0xFFFFFF80;
   - var 101 at addr 8 -> 0x00000080;
   - var 001 at addr 8 -> 0xFFFF8001;
   - var 100 at addr 8 -> 0x00008001;
   - var 010 at addr 8 -> 0x80010203, with done at T+6.
3. req0 and req1 held high continuously after reset -> grant order 0,1,0,1; never two gnt in one access; busy stays high through each access.
4. Word store 0x11223344 at addr 126 -> bytes written to 126, 127, 0, 1; a word load at 126 returns 0x11223344.
5. reset_n=0 at T+2 of a word store at addr 20 -> only the byte at 20 is written; mem_we=0 and done=0 from reset onward; gnt/rdata/busy=0.
6. Var 111 store and load, and var 011 load -> each behaves as a 4-byte word access.
